// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
//   Parametrised LIFO stack used as the call/return and operand stack of the
//   processor datapath. The width and depth are configurable. Push and pop
//   have separate strobes. A push and a pop in the same cycle replace the top
//   entry. The block also provides full/empty flags, an occupancy count, a
//   synchronous flush, and one-cycle overflow/underflow error pulses.
//
// Parameters
//   dw     data width in bits (>=1)
//   depth  number of entries (>=2, any value, not only powers of two)
//   aw     width of the count, $clog2(depth+1) (fixed, not overridable)
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_reset      synchronous active-high reset (highest priority)
//   i_clear      synchronous flush, same effect as reset, below reset
//   i_push       push i_din this cycle
//   i_pop        pop the top entry this cycle
//   i_din        data to push
//   o_dout       registered top-of-stack value, 0 when empty
//   o_empty      count == 0
//   o_full       count == depth
//   o_count      number of valid entries, 0..depth (registered)
//   o_overflow   1-cycle pulse: push rejected because the stack was full
//   o_underflow  1-cycle pulse: pop rejected because the stack was empty
// ---------------------------------------------------------------------------
module lifo_stack #(
  parameter  int dw    = 8,
  parameter  int depth = 16,
  localparam int aw    = $clog2(depth + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [dw-1:0] i_din,
  output logic [dw-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [aw-1:0] o_count,
  output logic          o_overflow,
  output logic          o_underflow
);

  // Storage index width. aw >= iw always holds, so slicing a count down to
  // iw bits is safe whenever the count value is below depth.
  localparam int iw = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [aw-1:0] c_zero = aw'(1'b0);
  localparam logic [aw-1:0] c_one  = aw'(1'b1);
  localparam logic [aw-1:0] c_two  = aw'(2'd2);
  localparam logic [aw-1:0] c_full = aw'(depth);

  logic [dw-1:0] r_mem [depth];
  logic [aw-1:0] r_count;
  logic [dw-1:0] r_dout;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic [aw-1:0] w_cnt_m1;
  logic [aw-1:0] w_cnt_m2;
  logic [aw-1:0] w_count_nxt;
  logic [dw-1:0] w_dout_nxt;
  logic          w_ovf_nxt;
  logic          w_udf_nxt;
  logic          w_we;
  logic [iw-1:0] w_waddr;
  logic [iw-1:0] w_raddr;

  assign w_empty  = (r_count == c_zero);
  assign w_full   = (r_count == c_full);
  assign w_cnt_m1 = r_count - c_one;
  assign w_cnt_m2 = r_count - c_two;

  // Decode this cycle's operation into the next count, top value, error pulses and memory write.
  always_comb begin
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_ovf_nxt   = 1'b0;
    w_udf_nxt   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = {iw{1'b0}};
    w_raddr     = {iw{1'b0}};
    case ({i_push, i_pop})
      2'b10: begin
        if (w_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_waddr     = r_count[iw-1:0];
          w_count_nxt = r_count + c_one;
          w_dout_nxt  = i_din;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_udf_nxt = 1'b1;
        end else if (r_count == c_one) begin
          w_count_nxt = c_zero;
          w_dout_nxt  = {dw{1'b0}};
        end else begin
          // The entry below the current top becomes the new top. The read
          // address is only formed when count >= 2, so it stays below depth.
          w_raddr     = w_cnt_m2[iw-1:0];
          w_count_nxt = w_cnt_m1;
          w_dout_nxt  = r_mem[w_raddr];
        end
      end
      2'b11: begin
        if (w_empty) begin
          // Nothing to replace: this behaves as a plain push into slot 0.
          w_we        = 1'b1;
          w_waddr     = {iw{1'b0}};
          w_count_nxt = c_one;
          w_dout_nxt  = i_din;
        end else begin
          // Replace the top entry. This is legal when full, because the
          // count does not change.
          w_we       = 1'b1;
          w_waddr    = w_cnt_m1[iw-1:0];
          w_dout_nxt = i_din;
        end
      end
      2'b00: begin
        w_count_nxt = r_count;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase
  end

  // Registered state and outputs; reset wins over clear, and clear wins over the decoded operation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count     <= c_zero;
      r_dout      <= {dw{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clear) begin
      r_count     <= c_zero;
      r_dout      <= {dw{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_dout      <= w_dout_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_udf_nxt;
    end
  end

  // Storage write port. The contents are not cleared; operations are dropped during reset or clear.
  always_ff @(posedge i_clk) begin
    if (w_we && !i_reset && !i_clear) begin
      r_mem[w_waddr] <= i_din;
    end
  end

  assign o_dout      = r_dout;
  assign o_count     = r_count;
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack
//   Self-checking bench for lifo_stack (dw=8, depth=4). A queue-based
//   reference model tracks the expected stack. Every cycle, all outputs are
//   compared against the model. Directed scenarios also carry fixed expected
//   constants.
// ---------------------------------------------------------------------------
module tb_lifo_stack;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          clear;
  logic          push;
  logic          pop;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW-1:0] count;
  logic          overflow;
  logic          underflow;

  int n_total;
  int n_bad;

  // reference model state
  logic [DW-1:0] q[$];
  logic          exp_ovf;
  logic          exp_udf;

  lifo_stack #(.dw(DW), .depth(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clear    (clear),
    .i_push     (push),
    .i_pop      (pop),
    .i_din      (din),
    .o_dout     (dout),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Apply one operation to the reference model, using the stack rules directly.
  task automatic model_apply(input logic r, input logic c, input logic p, input logic o,
                             input logic [DW-1:0] d);
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    if (r || c) begin
      q.delete();
    end else if (p && o) begin
      if (q.size() == 0) q.push_back(d);
      else q[q.size()-1] = d;
    end else if (p) begin
      if (q.size() == DEPTH) exp_ovf = 1'b1;
      else q.push_back(d);
    end else if (o) begin
      if (q.size() == 0) exp_udf = 1'b1;
      else void'(q.pop_back());
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] top;
    top = (q.size() == 0) ? 8'h00 : q[q.size()-1];
    chk({tag, ".dout"},  32'(dout),      32'(top));
    chk({tag, ".count"}, 32'(count),     32'(q.size()));
    chk({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    chk({tag, ".udf"},   32'(underflow), 32'(exp_udf));
  endtask

  // Drive one cycle's inputs on the falling edge, let the rising edge take
  // them, then sample 1 time unit later and compare against the model.
  task automatic cyc(input string tag, input logic r, input logic c, input logic p,
                     input logic o, input logic [DW-1:0] d);
    @(negedge clk);
    reset = r; clear = c; push = p; pop = o; din = d;
    @(posedge clk);
    #1;
    model_apply(r, c, p, o, d);
    check_model(tag);
  endtask

  initial begin
    int bias;
    n_total = 0;
    n_bad   = 0;
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;

    // 1: reset, then three pushes
    cyc("t1.rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t1.rst.count", 32'(count), 32'd0);
    chk("t1.rst.empty", 32'(empty), 32'd1);
    cyc("t1.p11", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    chk("t1.p11.dout", 32'(dout), 32'h11);
    cyc("t1.p22", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    cyc("t1.p33", 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    chk("t1.p33.dout", 32'(dout), 32'h33);
    chk("t1.p33.count", 32'(count), 32'd3);

    // 2: fill, overflow, then drain
    cyc("t2.p44", 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
    chk("t2.full", 32'(full), 32'd1);
    cyc("t2.p55", 1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    chk("t2.ovf", 32'(overflow), 32'd1);
    chk("t2.ovf.dout", 32'(dout), 32'h44);
    cyc("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("t2.ovf.drop", 32'(overflow), 32'd0);
    cyc("t2.pop1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t2.pop1.dout", 32'(dout), 32'h33);
    cyc("t2.pop2", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("t2.pop3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t2.pop3.dout", 32'(dout), 32'h11);
    cyc("t2.pop4", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t2.pop4.dout", 32'(dout), 32'h00);
    chk("t2.pop4.empty", 32'(empty), 32'd1);

    // 3: underflow, single and back-to-back
    cyc("t3.u1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t3.u1.udf", 32'(underflow), 32'd1);
    cyc("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc("t3.u2a", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("t3.u2b", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t3.u2b.udf", 32'(underflow), 32'd1);
    cyc("t3.idle2", 1'b0, 1'b0, 1'b0, 0, 8'h00);

    // 4: replace top (partial, full, empty)
    cyc("t4.p11", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    cyc("t4.p22", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    cyc("t4.rAA", 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
    chk("t4.rAA.dout", 32'(dout), 32'hAA);
    chk("t4.rAA.count", 32'(count), 32'd2);
    cyc("t4.pop", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t4.pop.dout", 32'(dout), 32'h11);
    cyc("t4.f2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
    cyc("t4.f3", 1'b0, 1'b0, 1'b1, 1'b0, 8'h03);
    cyc("t4.f4", 1'b0, 1'b0, 1'b1, 1'b0, 8'h04);
    cyc("t4.rBB", 1'b0, 1'b0, 1'b1, 1'b1, 8'hBB);
    chk("t4.rBB.dout", 32'(dout), 32'hBB);
    chk("t4.rBB.count", 32'(count), 32'd4);
    chk("t4.rBB.ovf", 32'(overflow), 32'd0);
    cyc("t4.popB", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t4.popB.dout", 32'(dout), 32'h03);
    cyc("t4.rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc("t4.rCC", 1'b0, 1'b0, 1'b1, 1'b1, 8'hCC);
    chk("t4.rCC.count", 32'(count), 32'd1);
    chk("t4.rCC.dout", 32'(dout), 32'hCC);
    chk("t4.rCC.udf", 32'(underflow), 32'd0);

    // 5: clear beats a simultaneous push
    cyc("t5.p1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h21);
    cyc("t5.p2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h31);
    chk("t5.count3", 32'(count), 32'd3);
    cyc("t5.clr", 1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
    chk("t5.clr.count", 32'(count), 32'd0);
    chk("t5.clr.dout", 32'(dout), 32'h00);
    chk("t5.clr.empty", 32'(empty), 32'd1);
    cyc("t5.p5A", 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    chk("t5.p5A.dout", 32'(dout), 32'h5A);
    chk("t5.p5A.count", 32'(count), 32'd1);

    // 6: randomized traffic against the model, with occasional reset/clear
    bias = 50;
    for (int i = 0; i < 10000; i++) begin
      logic r, c, p, o;
      if ((i % 200) == 0) bias = int'($urandom_range(20, 80));
      r = ($urandom_range(0, 499) == 0);
      c = ($urandom_range(0, 299) == 0);
      p = (int'($urandom_range(0, 99)) < bias);
      o = (int'($urandom_range(0, 99)) >= bias);
      if ($urandom_range(0, 9) == 0) begin
        p = 1'b1;
        o = 1'b1;
      end
      cyc("t6", r, c, p, o, 8'($urandom));
    end
    // explicit mid-traffic reset followed by reset-value checks
    cyc("t6.pre", 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    cyc("t6.rst", 1'b1, 1'b1, 1'b1, 1'b1, 8'h66);
    chk("t6.rst.count", 32'(count), 32'd0);
    chk("t6.rst.dout", 32'(dout), 32'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
